// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB: FSM states, PTE bit positions and
// the dirty/ref field layout used on the page-table write-back path.
package tlb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      WALK = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int PTE_VALID = 31;
   localparam int PTE_DIRTY = 30;
   localparam int PTE_REF   = 29;

   localparam int DR_DIRTY = 1;
   localparam int DR_REF   = 0;

endpackage

// File: rtl/tlb_lru.sv
// Age-based LRU for the TLB. Ages form a permutation of 0..ENTRIES-1, so the
// oldest entry is always the one whose age equals ENTRIES-1.
module tlb_lru
   import tlb_pkg::*;
#(
   parameter int ENTRIES = 4,
   localparam int IDX_W = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             touch_en,
   input  logic [IDX_W-1:0] touch_idx,
   output logic [IDX_W-1:0] victim_idx
);

   logic [IDX_W-1:0] age [ENTRIES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) age[i] <= IDX_W'(i);
      end else if (touch_en) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (IDX_W'(i) == touch_idx)
               age[i] <= '0;
            else if (age[i] < age[touch_idx])
               age[i] <= age[i] + 1'b1;
         end
      end
   end

   always_comb begin
      victim_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (age[i] == IDX_W'(ENTRIES - 1)) victim_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/tlb.sv
// Fully associative TLB with write-back of dirty/ref bits on eviction and a
// single-request page-table walk on a miss.
module tlb
   import tlb_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int VPN_W   = 6,
   parameter int PPN_W   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [VPN_W-1:0] req_vpn,
   input  logic             req_write,
   output logic             req_ready,
   output logic             resp_valid,
   output logic [PPN_W-1:0] resp_ppn,
   output logic             resp_fault,
   output logic [VPN_W-1:0] pt_vpn,
   output logic [1:0]       pt_dirty_ref,
   output logic             pt_write,
   input  logic             pt_fault,
   input  logic [31:0]      pt_ppn
);

   localparam int IDX_W = $clog2(ENTRIES);

   state_t           state;
   logic             e_valid [ENTRIES];
   logic [VPN_W-1:0] e_vpn   [ENTRIES];
   logic [PPN_W-1:0] e_ppn   [ENTRIES];
   logic             e_dirty [ENTRIES];
   logic             e_ref   [ENTRIES];

   logic [VPN_W-1:0] lat_vpn;
   logic             lat_write;
   logic [IDX_W-1:0] vic_idx;

   logic             accept, hit, free_found, walk_fault;
   logic [IDX_W-1:0] hit_idx, free_idx, lru_victim, miss_idx;
   logic             touch_en;
   logic [IDX_W-1:0] touch_idx;
   logic             unused_pte;

   assign accept     = req_valid && req_ready;
   assign walk_fault = pt_fault || !pt_ppn[PTE_VALID];
   assign miss_idx   = free_found ? free_idx : lru_victim;
   // The page table owns the authoritative dirty/ref bits; a walk only needs the PPN.
   assign unused_pte = ^{pt_ppn[PTE_DIRTY], pt_ppn[PTE_REF], pt_ppn[PTE_REF-1:PPN_W]};

   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (e_valid[i] && e_vpn[i] == req_vpn) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!e_valid[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      touch_en  = 1'b0;
      touch_idx = vic_idx;
      if (state == IDLE && accept && hit) begin
         touch_en  = 1'b1;
         touch_idx = hit_idx;
      end else if (state == WALK && !walk_fault) begin
         touch_en  = 1'b1;
      end
   end

   tlb_lru #(.ENTRIES(ENTRIES)) u_lru (
      .clk        (clk),
      .reset      (reset),
      .touch_en   (touch_en),
      .touch_idx  (touch_idx),
      .victim_idx (lru_victim)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_ppn     <= '0;
         resp_fault   <= 1'b0;
         pt_vpn       <= '0;
         pt_dirty_ref <= '0;
         pt_write     <= 1'b0;
         lat_vpn      <= '0;
         lat_write    <= 1'b0;
         vic_idx      <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            e_valid[i] <= 1'b0;
            e_vpn[i]   <= '0;
            e_ppn[i]   <= '0;
            e_dirty[i] <= 1'b0;
            e_ref[i]   <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_vpn   <= req_vpn;
                  lat_write <= req_write;
                  req_ready <= 1'b0;
                  if (hit) begin
                     e_ref[hit_idx] <= 1'b1;
                     if (req_write) e_dirty[hit_idx] <= 1'b1;
                     resp_valid <= 1'b1;
                     resp_ppn   <= e_ppn[hit_idx];
                     resp_fault <= 1'b0;
                     state      <= RESP;
                  end else begin
                     vic_idx <= miss_idx;
                     if (e_valid[miss_idx]) begin
                        pt_vpn                 <= e_vpn[miss_idx];
                        pt_dirty_ref[DR_DIRTY] <= e_dirty[miss_idx];
                        pt_dirty_ref[DR_REF]   <= e_ref[miss_idx];
                        pt_write               <= 1'b1;
                        state                  <= WB;
                     end else begin
                        pt_vpn <= req_vpn;
                        state  <= WALK;
                     end
                  end
               end
            end
            WB: begin
               // Victim leaves the cache here so a faulting walk cannot resurrect it.
               e_valid[vic_idx] <= 1'b0;
               pt_write         <= 1'b0;
               pt_vpn           <= lat_vpn;
               state            <= WALK;
            end
            WALK: begin
               resp_valid <= 1'b1;
               if (walk_fault) begin
                  resp_fault <= 1'b1;
                  resp_ppn   <= '0;
               end else begin
                  resp_fault       <= 1'b0;
                  resp_ppn         <= pt_ppn[PPN_W-1:0];
                  e_valid[vic_idx] <= 1'b1;
                  e_vpn[vic_idx]   <= lat_vpn;
                  e_ppn[vic_idx]   <= pt_ppn[PPN_W-1:0];
                  e_ref[vic_idx]   <= 1'b1;
                  e_dirty[vic_idx] <= lat_write;
               end
               state <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlb.sv
// Bench for tlb: a page-table model, a vector table of translations with
// expected latency and write-backs, and hand sequences for reset and request hold.
module tb_tlb;

   localparam int ENTRIES = 4;
   localparam int VPN_W   = 6;
   localparam int PPN_W   = 2;
   localparam logic [VPN_W-1:0] FAULT_VPN = 6'd11;

   logic             clk;
   logic             reset;
   logic             req_valid;
   logic [VPN_W-1:0] req_vpn;
   logic             req_write;
   logic             req_ready;
   logic             resp_valid;
   logic [PPN_W-1:0] resp_ppn;
   logic             resp_fault;
   logic [VPN_W-1:0] pt_vpn;
   logic [1:0]       pt_dirty_ref;
   logic             pt_write;
   logic             pt_fault;
   logic [31:0]      pt_ppn;

   logic [31:0] pt_mem [64];

   tlb #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_vpn      (req_vpn),
      .req_write    (req_write),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_ppn     (resp_ppn),
      .resp_fault   (resp_fault),
      .pt_vpn       (pt_vpn),
      .pt_dirty_ref (pt_dirty_ref),
      .pt_write     (pt_write),
      .pt_fault     (pt_fault),
      .pt_ppn       (pt_ppn)
   );

   assign pt_ppn   = pt_mem[pt_vpn];
   assign pt_fault = (pt_vpn == FAULT_VPN);

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: exp_q holds {latency[2:0], fault, ppn[1:0]}; wb_q holds {vpn, dirty, ref}
   logic [5:0] exp_q [$];
   int         acc_q [$];
   logic [7:0] wb_q  [$];
   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [2:0] walk_exp(input logic [VPN_W-1:0] v);
      if (!pt_mem[v][31] || v == FAULT_VPN) return 3'b100;
      return {1'b0, pt_mem[v][1:0]};
   endfunction

   always @(negedge clk) begin
      logic [5:0] e;
      logic [7:0] w;
      int a;
      if (!reset) begin
         if (resp_valid) begin
            chk("resp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("resp_ppn", 32'(resp_ppn), 32'(e[1:0]));
               chk("resp_fault", 32'(resp_fault), 32'(e[2]));
               chk("resp_latency", 32'(cyc - a), 32'(e[5:3]));
            end
         end
         if (pt_write) begin
            chk("wb_expected", 32'(wb_q.size() != 0), 1);
            if (wb_q.size() != 0) begin
               w = wb_q.pop_front();
               chk("wb_vpn", 32'(pt_vpn), 32'(w[7:2]));
               chk("wb_dirty_ref", 32'(pt_dirty_ref), 32'(w[1:0]));
            end
         end
      end
   end

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_ppn", 32'(resp_ppn), 0);
      chk("rst_resp_fault", 32'(resp_fault), 0);
      chk("rst_pt_write", 32'(pt_write), 0);
      chk("rst_pt_vpn", 32'(pt_vpn), 0);
      chk("rst_pt_dirty_ref", 32'(pt_dirty_ref), 0);
      reset = 1'b0;
      exp_q.delete();
      acc_q.delete();
      wb_q.delete();
   endtask

   task automatic issue(input logic [VPN_W-1:0] v, input logic w, input int lat,
                        input logic wb, input logic [VPN_W-1:0] wbv,
                        input logic [1:0] wbdr, input bit junk);
      int budget;
      @(negedge clk);
      budget = 0;
      while (!req_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      chk("req_ready_idle", 32'(req_ready), 1);
      exp_q.push_back({3'(lat), walk_exp(v)});
      acc_q.push_back(cyc);
      if (wb) wb_q.push_back({wbv, wbdr});
      req_valid = 1'b1;
      req_vpn   = v;
      req_write = w;
      budget    = 0;
      while (budget < 20) begin
         @(negedge clk);
         #1;
         budget++;
         if (exp_q.size() == 0) break;
         if (junk) begin
            req_vpn   = 6'($urandom_range(0, 63));
            req_write = 1'($urandom_range(0, 1));
         end else begin
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      if (exp_q.size() != 0) begin
         chk("resp_timeout", 32'(exp_q.size()), 0);
         exp_q.delete();
         acc_q.delete();
      end
      chk("wb_drained", 32'(wb_q.size()), 0);
      wb_q.delete();
   endtask

   typedef struct {
      bit               rst;
      logic [VPN_W-1:0] vpn;
      logic             wr;
      int               lat;
      logic             wb;
      logic [VPN_W-1:0] wbv;
      logic [1:0]       wbdr;
   } vec_t;

   vec_t vecs [18];

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_vpn   = '0;
      req_write = 1'b0;
      for (int i = 0; i < 64; i++)
         pt_mem[i] = 32'h8000_0000 | (32'(i) << 2) | 32'((i * 3 + 2) % 4)
                     | ((i % 2 == 1) ? 32'h6000_0000 : 32'h0);
      pt_mem[1]  = 32'h8000_0001;
      pt_mem[10] = 32'h0000_0003;

      vecs[0]  = '{0, 6'd1,  1'b0, 2, 1'b0, 6'd0, 2'b00};
      vecs[1]  = '{0, 6'd1,  1'b0, 1, 1'b0, 6'd0, 2'b00};
      vecs[2]  = '{0, 6'd10, 1'b0, 2, 1'b0, 6'd0, 2'b00};
      vecs[3]  = '{0, 6'd10, 1'b0, 2, 1'b0, 6'd0, 2'b00};
      vecs[4]  = '{1, 6'd0,  1'b0, 2, 1'b0, 6'd0, 2'b00};
      vecs[5]  = '{0, 6'd1,  1'b0, 2, 1'b0, 6'd0, 2'b00};
      vecs[6]  = '{0, 6'd2,  1'b1, 2, 1'b0, 6'd0, 2'b00};
      vecs[7]  = '{0, 6'd3,  1'b0, 2, 1'b0, 6'd0, 2'b00};
      vecs[8]  = '{0, 6'd4,  1'b0, 3, 1'b1, 6'd0, 2'b01};
      vecs[9]  = '{0, 6'd5,  1'b0, 3, 1'b1, 6'd1, 2'b01};
      vecs[10] = '{0, 6'd0,  1'b0, 3, 1'b1, 6'd2, 2'b11};
      vecs[11] = '{0, 6'd3,  1'b1, 1, 1'b0, 6'd0, 2'b00};
      vecs[12] = '{0, 6'd4,  1'b0, 1, 1'b0, 6'd0, 2'b00};
      vecs[13] = '{0, 6'd5,  1'b0, 1, 1'b0, 6'd0, 2'b00};
      vecs[14] = '{0, 6'd0,  1'b0, 1, 1'b0, 6'd0, 2'b00};
      vecs[15] = '{0, 6'd6,  1'b0, 3, 1'b1, 6'd3, 2'b11};
      vecs[16] = '{0, 6'd11, 1'b0, 3, 1'b1, 6'd4, 2'b01};
      vecs[17] = '{0, 6'd4,  1'b0, 2, 1'b0, 6'd0, 2'b00};

      do_reset();
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].rst) do_reset();
         issue(vecs[i].vpn, vecs[i].wr, vecs[i].lat, vecs[i].wb,
               vecs[i].wbv, vecs[i].wbdr, 1'b0);
      end

      // reset while the write-back of vpn 5 is on the bus
      @(negedge clk);
      wb_q.push_back({6'd5, 2'b01});
      req_valid = 1'b1;
      req_vpn   = 6'd7;
      req_write = 1'b0;
      @(negedge clk);
      chk("wb_before_reset", 32'(pt_write), 1);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      chk("reset_drops_pt_write", 32'(pt_write), 0);
      chk("reset_drops_resp", 32'(resp_valid), 0);
      chk("reset_req_ready", 32'(req_ready), 1);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_resp_after_reset", 32'(resp_valid), 0);
      end
      chk("reset_wb_drained", 32'(wb_q.size()), 0);
      wb_q.delete();

      issue(6'd4, 1'b0, 2, 1'b0, 6'd0, 2'b00, 1'b0);
      // request held with a wandering vpn while busy
      issue(6'd9, 1'b0, 2, 1'b0, 6'd0, 2'b00, 1'b1);
      issue(6'd9, 1'b0, 1, 1'b0, 6'd0, 2'b00, 1'b1);
      issue(6'd4, 1'b0, 1, 1'b0, 6'd0, 2'b00, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tlb.md
# tlb

Fully associative translation lookaside buffer placed directly upstream of the page table. It caches VPN→PPN translations together with per-entry dirty/ref bits. On a miss it walks the page table, and on eviction it writes the victim's dirty/ref bits back to the page table. Translation responses go to the memory-access stage.

## Interface
Parameters:
- ENTRIES, 4: number of TLB entries; power of two, at least 2.
- VPN_W, 6: virtual page number width. This equals the page-table index width.
- PPN_W, 2: physical page number width, taken from PTE bits [PPN_W-1:0].

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  translation request present.
- req_vpn  in  VPN_W  virtual page number to translate.
- req_write  in  1  the access is a store; it sets the dirty bit.
- req_ready  out  1  block can accept a request; high only in IDLE.
- resp_valid  out  1  one-cycle pulse; the response is valid.
- resp_ppn  out  PPN_W  translated PPN; 0 when resp_fault is high.
- resp_fault  out  1  page fault; the PTE valid bit is 0.
- pt_vpn  out  VPN_W  index driven into the page table.
- pt_dirty_ref  out  2  bit [1] is dirty, bit [0] is ref; lands in PTE[30:29].
- pt_write  out  1  one-cycle write strobe to the page table.
- pt_fault  in  1  page-table fault for pt_vpn; combinational.
- pt_ppn  in  32  PTE for pt_vpn; combinational. Bit [31] is valid, [30] dirty, [29] ref.

## Operation
- Each entry holds valid, vpn, ppn, dirty and ref.
- A request is accepted when req_valid && req_ready. The block latches req_vpn and req_write.
- Hit: some valid entry has vpn == req_vpn.
  - The entry's ref bit is set to 1. If req_write, its dirty bit is set to 1.
  - The entry's LRU age is updated.
  - The response returns the entry's ppn with resp_fault=0.
  - No page-table access takes place.
- Miss: the block selects a victim.
  - The victim is the lowest-index invalid entry if one exists; otherwise it is the entry with the oldest LRU age.
  - If the victim is valid, a write-back is performed: pt_vpn = victim vpn, pt_dirty_ref = {dirty, ref}, pt_write = 1 for one cycle.
  - The block then walks the page table: pt_vpn = latched vpn, pt_write = 0, and it samples pt_fault and pt_ppn.
- Walk result:
  - If pt_fault: resp_fault=1, resp_ppn=0, and no fill. The victim has still been written back and invalidated.
  - Otherwise the victim is filled with valid=1, ppn=pt_ppn[PPN_W-1:0], ref=1, dirty=req_write, and its LRU age is updated.
- LRU uses one age counter per entry, log2(ENTRIES) bits each, reset to the entry index.
  - On a touch of entry e, every age smaller than age[e] increments and age[e] becomes 0.
  - The victim is the entry whose age is ENTRIES-1.
- State machine:
  - IDLE goes to RESP on a hit, to WB on a miss with a valid victim, and to WALK on a miss with an invalid victim.
  - WB goes to WALK.
  - WALK goes to RESP.
  - RESP goes to IDLE.
- req_valid is ignored outside IDLE. The requester holds the request until it sees req_ready.
- The TLB uses a write-back policy: hits never write the page table.

## Timing
- Reset values:
  - State is IDLE; all entries have valid=0; age[i]=i.
  - req_ready=1; resp_valid=0; resp_ppn=0; resp_fault=0.
  - pt_write=0; pt_vpn=0; pt_dirty_ref=0.
- Reset asserted mid-operation aborts to IDLE, drops the response, and deasserts pt_write in the same cycle.
- Let cycle 0 be the cycle in which the request is accepted.
  - Hit: resp_valid in cycle 1.
  - Miss with an invalid victim: WALK in cycle 1, resp_valid in cycle 2.
  - Miss with a valid victim: WB (pt_write=1) in cycle 1, WALK in cycle 2, resp_valid in cycle 3.
- resp_valid, resp_ppn and resp_fault are registered. resp_valid is high for exactly one cycle and there is no backpressure. resp_ppn and resp_fault hold their values until the next response.
- pt_vpn, pt_dirty_ref and pt_write are registered and change only on a state transition.
- In WALK, pt_fault and pt_ppn are sampled on the clock edge at the end of the WALK cycle.
- req_ready is low from cycle 1 until RESP completes. The next request can be accepted in the cycle after RESP.

## Structure
- Package tlb_pkg holds:
  - the state enum (IDLE, WB, WALK, RESP);
  - PTE field constants: PTE_VALID=31, PTE_DIRTY=30, PTE_REF=29;
  - the dirty/ref bit positions (DR_DIRTY=1, DR_REF=0).
- Sub-module tlb_lru holds the age counters and computes the victim index. Its inputs are touch_en and touch_idx; its output is victim_idx.
- The tag compare, entry array and FSM live in tlb.

## Test plan
- After reset, a read of vpn=1 against a PTE of 0x80000001 gives a miss. resp_valid occurs in cycle 2 with resp_ppn=2'b01 and resp_fault=0, and pt_write is never asserted. Repeating vpn=1 gives a hit with resp_valid in cycle 1.
- A read of vpn=10 where PTE valid=0 gives resp_valid in cycle 2 with resp_fault=1 and resp_ppn=0. A repeat of vpn=10 misses again, proving there was no fill.
- Run the access sequence 0, 1, 2(write), 3, 4, 5, 0.
  - vpn 4 evicts vpn 0 with pt_write=1, pt_vpn=0, pt_dirty_ref=2'b01.
  - vpn 5 evicts vpn 1 with pt_dirty_ref=2'b01.
  - vpn 0 evicts vpn 2 with pt_dirty_ref=2'b11.
  - Each of these responses appears in cycle 3.
- A write hit on a cached vpn=3 produces no pt_write. A later eviction of vpn 3 writes pt_dirty_ref=2'b11.
- Assert reset during WB:
  - pt_write drops immediately and no resp_valid is produced.
  - req_ready is 1 in the first cycle after reset.
  - A following request for a previously cached vpn misses.
- Hold req_valid high with a changing req_vpn while req_ready=0: the latched vpn is unchanged and the response corresponds to the originally accepted vpn.
